// File: rtl/m_instrgen_pkg.sv
// Shared definitions for the midgetv self-test instruction generator:
// RV32I major opcodes, LFSR feedback mask and generator state encoding.
package m_instrgen_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_ILL_IMM32 = 7'b0011011;

    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_HOLD,
        S_DONE
    } state_t;

    // Galois step: shift right, fold the mask in when a one falls off the end.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/m_instrgen_enc.sv
// Combinational encoder: turns a random word into an RV32I instruction that is
// guaranteed legal, or guaranteed illegal, under full decode.
module m_instrgen_enc
    import m_instrgen_pkg::*;
#(
    parameter int MULDIV = 0
) (
    input  logic [31:0] r,
    input  logic        want_illegal,
    output logic [31:0] word
);

    logic [31:0] legal;

    always_comb begin
        legal = r;
        case (r[3:0])
            4'd0: begin
                legal[6:0] = OPC_LOAD;
                case (r[14:12])
                    3'b011:  legal[14:12] = 3'b010;
                    3'b110:  legal[14:12] = 3'b100;
                    3'b111:  legal[14:12] = 3'b101;
                    default: ;
                endcase
            end
            4'd1: begin
                legal[6:0]   = OPC_STORE;
                legal[14:12] = (r[13:12] == 2'b11) ? 3'b010 : {1'b0, r[13:12]};
            end
            4'd3: begin
                legal[6:0]   = OPC_OP;
                legal[31:25] = '0;
                if (r[14:12] == 3'b000 || r[14:12] == 3'b101)
                    legal[30] = r[30];
                if (MULDIV != 0 && r[25])
                    legal[31:25] = 7'b0000001;
            end
            4'd4: legal[6:0] = OPC_LUI;
            4'd5: legal[6:0] = OPC_AUIPC;
            4'd6: legal[6:0] = OPC_JAL;
            4'd7: begin
                legal[6:0]   = OPC_JALR;
                legal[14:12] = '0;
            end
            4'd8: begin
                legal[6:0] = OPC_BRANCH;
                if (r[14:13] == 2'b01)
                    legal[14:12] = {2'b00, r[12]};
            end
            4'd9: begin
                legal[6:0]   = OPC_MISC_MEM;
                legal[14:12] = {2'b00, r[12]};
            end
            4'd10: begin
                legal[6:0]   = OPC_SYSTEM;
                legal[31:20] = 12'h340;
                if (r[14:12] == 3'b000)
                    legal[14:12] = 3'b001;
                else if (r[14:12] == 3'b100)
                    legal[14:12] = 3'b010;
            end
            default: begin
                legal[6:0] = OPC_OP_IMM;
                if (r[14:12] == 3'b001)
                    legal[31:25] = '0;
                else if (r[14:12] == 3'b101)
                    legal[31:25] = {1'b0, r[30], 5'b00000};
            end
        endcase
    end

    always_comb begin
        word = r;
        if (!want_illegal) begin
            word = legal;
        end else begin
            case (r[5:4])
                2'b00: word = {legal[31:2], 2'b00};
                2'b01: word[6:0] = OPC_ILL_IMM32;
                2'b10: begin
                    word[6:0]   = OPC_OP;
                    word[31:25] = 7'b0000010;
                end
                default: begin
                    word[6:0]   = OPC_SYSTEM;
                    word[14:12] = 3'b000;
                    word[11:7]  = 5'b00001;
                    word[19:15] = 5'b00000;
                end
            endcase
        end
    end

endmodule

// File: rtl/m_instrgen.sv
// Burst controller for the self-test instruction generator: LFSR, FSM,
// word counters and the registered valid/ready output stage.
module m_instrgen
    import m_instrgen_pkg::*;
#(
    parameter int          MULDIV = 0,
    parameter logic [31:0] SEED   = 32'h00000001
) (
    input  logic        CLK,
    input  logic        RESET_I,
    input  logic        start,
    input  logic [15:0] count,
    input  logic        want_illegal,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_instr,
    output logic        o_expect_illegal,
    output logic        busy,
    output logic        done,
    output logic [15:0] n_emitted
);

    state_t      state;
    logic [31:0] lfsr;
    logic [31:0] lfsr_nxt;
    logic [31:0] enc_word;
    logic [15:0] remaining;

    assign lfsr_nxt = lfsr_step(lfsr);

    m_instrgen_enc #(.MULDIV(MULDIV)) u_enc (
        .r            (lfsr_nxt),
        .want_illegal (o_expect_illegal),
        .word         (enc_word)
    );

    always_ff @(posedge CLK or posedge RESET_I) begin
        if (RESET_I) begin
            state            <= S_IDLE;
            lfsr             <= SEED;
            remaining        <= '0;
            o_valid          <= 1'b0;
            o_instr          <= '0;
            o_expect_illegal <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            n_emitted        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        n_emitted <= '0;
                        if (count == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            remaining        <= count;
                            o_expect_illegal <= want_illegal;
                            state            <= S_GEN;
                        end
                    end
                end
                S_GEN: begin
                    lfsr    <= lfsr_nxt;
                    o_instr <= enc_word;
                    o_valid <= 1'b1;
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (o_ready) begin
                        o_valid   <= 1'b0;
                        n_emitted <= n_emitted + 16'd1;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_GEN;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_instrgen.sv
// Randomized scoreboard bench for m_instrgen: expected words come from an
// independent field-level model; a negedge monitor pops and compares on handshake.
module tb_m_instrgen;

    localparam int          MD     = 1;
    localparam logic [31:0] SEED_V = 32'h00000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] count = '0;
    logic        want_illegal = 1'b0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [31:0] o_instr;
    logic        o_expect_illegal;
    logic        busy;
    logic        done;
    logic [15:0] n_emitted;

    m_instrgen #(.MULDIV(MD), .SEED(SEED_V)) dut (
        .CLK              (clk),
        .RESET_I          (rst),
        .start            (start),
        .count            (count),
        .want_illegal     (want_illegal),
        .o_valid          (o_valid),
        .o_ready          (o_ready),
        .o_instr          (o_instr),
        .o_expect_illegal (o_expect_illegal),
        .busy             (busy),
        .done             (done),
        .n_emitted        (n_emitted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [31:0] mlfsr = SEED_V;
    bit   seen_var[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] v);
        if (v % 2 == 1) return (v / 2) ^ 32'h80200003;
        return v / 2;
    endfunction

    // Field-level model of the encoding rules.
    function automatic logic [31:0] model_word(input logic [31:0] r, input logic ill);
        int load_map[8]   = '{0, 1, 2, 2, 4, 5, 4, 5};
        int store_map[4]  = '{0, 1, 2, 2};
        int branch_map[8] = '{0, 1, 0, 1, 4, 5, 6, 7};
        int csr_map[8]    = '{1, 1, 2, 3, 2, 5, 6, 7};
        logic [6:0] f7  = r[31:25];
        logic [4:0] rs2 = r[24:20];
        logic [4:0] rs1 = r[19:15];
        logic [2:0] f3  = r[14:12];
        logic [4:0] rd  = r[11:7];
        logic [6:0] opc;
        logic [31:0] w;
        int cls = int'(r[3:0]);
        case (cls)
            0: begin opc = 7'h03; f3 = 3'(load_map[f3]); end
            1: begin opc = 7'h23; f3 = 3'(store_map[r[13:12]]); end
            3: begin
                opc = 7'h33;
                f7  = 7'h00;
                if (f3 == 0 || f3 == 5) f7 = r[30] ? 7'h20 : 7'h00;
                if (MD != 0 && r[25]) f7 = 7'h01;
            end
            4: opc = 7'h37;
            5: opc = 7'h17;
            6: opc = 7'h6F;
            7: begin opc = 7'h67; f3 = 3'd0; end
            8: begin opc = 7'h63; f3 = 3'(branch_map[f3]); end
            9: begin opc = 7'h0F; f3 = r[12] ? 3'd1 : 3'd0; end
            10: begin opc = 7'h73; f7 = 7'h1A; rs2 = 5'd0; f3 = 3'(csr_map[f3]); end
            default: begin
                opc = 7'h13;
                if (f3 == 1) f7 = 7'h00;
                if (f3 == 5) f7 = r[30] ? 7'h20 : 7'h00;
            end
        endcase
        w = {f7, rs2, rs1, f3, rd, opc};
        if (!ill) return w;
        case ((r >> 4) & 32'd3)
            32'd0: return w & ~32'd3;
            32'd1: return {r[31:7], 7'h1B};
            32'd2: return {7'h02, r[24:7], 7'h33};
            default: return {r[31:20], 5'd0, 3'd0, 5'd1, 7'h73};
        endcase
    endfunction

    // Independent full RV32I(+M) legality decode.
    function automatic logic is_illegal(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        case (op)
            7'h03: return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            7'h23: return !(f3 inside {3'd0, 3'd1, 3'd2});
            7'h13: begin
                if (f3 == 1) return f7 != 0;
                if (f3 == 5) return !(f7 == 7'h00 || f7 == 7'h20);
                return 1'b0;
            end
            7'h33: begin
                if (f7 == 7'h00) return 1'b0;
                if (f7 == 7'h20) return !(f3 == 0 || f3 == 5);
                if (f7 == 7'h01) return MD == 0;
                return 1'b1;
            end
            7'h37, 7'h17, 7'h6F: return 1'b0;
            7'h67: return f3 != 0;
            7'h63: return f3 == 2 || f3 == 3;
            7'h0F: return f3 > 1;
            7'h73: begin
                if (f3 == 4) return 1'b1;
                if (f3 == 0)
                    return !(w[11:7] == 0 && w[19:15] == 0 &&
                             w[31:20] inside {12'h000, 12'h001, 12'h302, 12'h105});
                return 1'b0;
            end
            default: return 1'b1;
        endcase
    endfunction

    // Monitor: checks words at handshake and stability under backpressure.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr = '0;
    logic [32:0] e;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_stable", o_instr, prev_instr);
            end
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected none", o_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", o_instr, e[31:0]);
                    chk("expect_illegal", 32'(o_expect_illegal), 32'(e[32]));
                    chk("decode_status", 32'(is_illegal(o_instr)), 32'(e[32]));
                end
            end
            prev_stall = o_valid && !o_ready;
            prev_instr = o_instr;
        end
    end

    task automatic start_burst(input int n, input logic ill);
        logic [31:0] r;
        for (int i = 0; i < 200 && busy; i++) @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        count = 16'(n);
        want_illegal = ill;
        for (int i = 0; i < n; i++) begin
            mlfsr = ref_next(mlfsr);
            r = mlfsr;
            exp_q.push_back({ill, model_word(r, ill)});
            if (ill) seen_var[r[5:4]] = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int pct, input int maxc, input string name);
        bit got = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(posedge clk);
            #1;
            if (done) got = 1;
            else o_ready = ($urandom_range(99) < 32'(pct));
        end
        chk(name, 32'(got), 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_n_emitted", 32'(n_emitted), 32'd0);
        chk("rst_expect_illegal", 32'(o_expect_illegal), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-word burst: latency and done pulse
        o_ready = 1'b1;
        start_burst(1, 1'b0);
        chk("valid_edge_k1", 32'(o_valid), 32'd0);
        chk("busy_in_gen", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("valid_edge_k2", 32'(o_valid), 32'd1);
        @(posedge clk); #1;
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_valid_drop", 32'(o_valid), 32'd0);
        chk("basic_n_emitted", 32'(n_emitted), 32'd1);
        @(posedge clk); #1;
        chk("basic_done_once", 32'(done), 32'd0);
        chk("basic_busy_low", 32'(busy), 32'd0);

        // Zero count
        start_burst(0, 1'b0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_valid", 32'(o_valid), 32'd0);
        chk("zero_n_emitted", 32'(n_emitted), 32'd0);
        @(posedge clk); #1;
        chk("zero_idle", 32'(busy), 32'd0);
        chk("zero_valid_after", 32'(o_valid), 32'd0);

        // Backpressure for 20 cycles with a stray start in HOLD
        o_ready = 1'b0;
        start_burst(3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(o_valid), 32'd1);
            start = (i == 10);
            count = 16'd50;
            want_illegal = 1'b1;
        end
        start = 1'b0;
        wait_done(100, 100, "bp_done");
        chk("ignored_start_count", 32'(n_emitted), 32'd3);
        chk("ignored_start_type", 32'(o_expect_illegal), 32'd0);

        // Long random-ready legal burst
        start_burst(1000, 1'b0);
        wait_done(50, 20000, "legal_done");
        chk("legal_n_emitted", 32'(n_emitted), 32'd1000);

        // Long random-ready illegal burst
        start_burst(1000, 1'b1);
        wait_done(50, 20000, "illegal_done");
        chk("illegal_n_emitted", 32'(n_emitted), 32'd1000);
        for (int v = 0; v < 4; v++) chk("variant_seen", 32'(seen_var[v]), 32'd1);

        // Reset while word 5 of 10 is held
        o_ready = 1'b1;
        start_burst(10, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (n_emitted == 16'd4) begin
                o_ready = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_hold_valid", 32'(o_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(o_valid), 32'd0);
        chk("async_rst_n_emitted", 32'(n_emitted), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        mlfsr = SEED_V;
        @(posedge clk); #1;
        rst = 1'b0;
        o_ready = 1'b1;
        start_burst(10, 1'b0);
        wait_done(100, 200, "restart_done");
        chk("restart_n_emitted", 32'(n_emitted), 32'd10);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
